// File: rtl/arm_mem_pkg.sv
// Shared definitions for the ARM MEM-stage SRAM controller.
//   MEM_DATA_BASE   : byte address mapped to SRAM word 0
//   MEM_WAIT_CYCLES : default hold time of each 16-bit SRAM access
//   mem_state_t     : access FSM states
//   mem_req_t       : request fields captured when an access starts
package arm_mem_pkg;

  localparam int MEM_DATA_BASE   = 1024;
  localparam int MEM_WAIT_CYCLES = 2;
  localparam int WAIT_W          = 4;   // wait counter width, holds 1..15

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  typedef struct packed {
    logic        wr;     // 1 = write, 0 = read
    logic [16:0] word;   // SRAM 32-bit word index
    logic [31:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/sram_controller_if.sv
// MEM-stage request/response bus between the pipeline and the SRAM controller.
//   master : pipeline side (drives requests, receives load data / ready)
//   slave  : controller side
interface sram_controller_if;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (output wr_en, rd_en, address, write_data,
                  input  read_data, ready);
  modport slave  (input  wr_en, rd_en, address, write_data,
                  output read_data, ready);
endinterface

// File: rtl/sram_wait_counter.sv
// Load/decrement counter timing each SRAM half-word phase.
//   clk, rst  : clock, async active-low reset
//   load      : load load_val (has priority over dec)
//   load_val  : cycles-1 for the phase about to start
//   dec       : decrement, saturating at zero
//   tc        : terminal count, high when the count is zero
module sram_wait_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                     count <= '0;
    else if (load)                count <= load_val;
    else if (dec && count != '0)  count <= count - 1'b1;
  end

  assign tc = (count == '0);

endmodule

// File: rtl/sram_controller.sv
// ARM MEM-stage to 16-bit asynchronous SRAM controller. Each 32-bit access
// is split into a low half-word phase (LOW) and a high half-word phase
// (HIGH), each held WAIT_CYCLES cycles, followed by a one-cycle DONE.
//   clk, rst      : clock, async active-low reset
//   bus (slave)   : wr_en/rd_en/address/write_data in, read_data/ready out
//   sram_addr     : half-word address {word, half}
//   sram_dq_out/_in/_oe : split bidirectional data bus
//   sram_we_n/oe_n/ce_n : active-low strobes
module sram_controller
  import arm_mem_pkg::*;
#(
  parameter int WAIT_CYCLES = MEM_WAIT_CYCLES,
  parameter int DATA_BASE   = MEM_DATA_BASE
) (
  input  logic                     clk,
  input  logic                     rst,
  sram_controller_if.slave         bus,
  output logic [17:0]              sram_addr,
  output logic [15:0]              sram_dq_out,
  input  logic [15:0]              sram_dq_in,
  output logic                     sram_dq_oe,
  output logic                     sram_we_n,
  output logic                     sram_oe_n,
  output logic                     sram_ce_n
);

  mem_state_t  state, state_nx;
  mem_req_t    req_q, req_live, req_sel;
  logic        req_in;
  logic [31:0] offs;
  logic        unused_offs;
  logic        cnt_load, cnt_dec, cnt_tc;
  logic [15:0] rd_lo;
  logic [31:0] read_data_q;

  assign req_in      = bus.wr_en | bus.rd_en;
  assign offs        = bus.address - 32'(DATA_BASE);
  assign unused_offs = ^{offs[31:19], offs[1:0]};

  // Write wins when both enables are high.
  always_comb begin
    req_live       = '0;
    req_live.wr    = bus.wr_en;
    req_live.word  = offs[18:2];
    req_live.wdata = bus.write_data;
  end

  // The SRAM pins are registered from the next state, so on the IDLE->LOW
  // edge they must see the live request rather than the not-yet-latched copy.
  assign req_sel = (state == IDLE) ? req_live : req_q;

  sram_wait_counter #(.WIDTH(WAIT_W)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (WAIT_W'(WAIT_CYCLES - 1)),
    .dec      (cnt_dec),
    .tc       (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state)
      IDLE: if (req_in) begin
        state_nx = LOW;
        cnt_load = 1'b1;
      end
      LOW: if (cnt_tc) begin
        state_nx = HIGH;
        cnt_load = 1'b1;
      end else begin
        cnt_dec  = 1'b1;
      end
      HIGH: if (cnt_tc) state_nx = DONE;
            else        cnt_dec  = 1'b1;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Reset term keeps ready high while rst is held even with a request present.
  assign bus.ready = !rst || (state == IDLE && !req_in) || (state == DONE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                      req_q <= '0;
    else if (state == IDLE && req_in) req_q <= req_live;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_ce_n   <= 1'b1;
    end else begin
      case (state_nx)
        LOW, HIGH: begin
          sram_addr  <= {req_sel.word, state_nx == HIGH};
          sram_ce_n  <= 1'b0;
          sram_we_n  <= !req_sel.wr;
          sram_oe_n  <= req_sel.wr;
          sram_dq_oe <= req_sel.wr;
          if (req_sel.wr)
            sram_dq_out <= (state_nx == HIGH) ? req_sel.wdata[31:16]
                                              : req_sel.wdata[15:0];
        end
        default: begin
          sram_ce_n  <= 1'b1;
          sram_we_n  <= 1'b1;
          sram_oe_n  <= 1'b1;
          sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  // Low half is parked in rd_lo so read_data changes only when a read completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_lo       <= '0;
      read_data_q <= '0;
    end else if (!req_q.wr && cnt_tc) begin
      if (state == LOW)  rd_lo       <= sram_dq_in;
      if (state == HIGH) read_data_q <= {sram_dq_in, rd_lo};
    end
  end

  assign bus.read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller with a behavioural 16-bit SRAM.
module tb_sram_controller;
  import arm_mem_pkg::*;

  localparam int W = 2;

  logic        clk, rst;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out, sram_dq_in;
  logic        sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n;

  sram_controller_if bus ();

  sram_controller #(.WAIT_CYCLES(W), .DATA_BASE(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sram_addr   (sram_addr),
    .sram_dq_out (sram_dq_out),
    .sram_dq_in  (sram_dq_in),
    .sram_dq_oe  (sram_dq_oe),
    .sram_we_n   (sram_we_n),
    .sram_oe_n   (sram_oe_n),
    .sram_ce_n   (sram_ce_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model
  logic [15:0] mem [0:262143];
  always @(posedge clk)
    if (!sram_ce_n && !sram_we_n) mem[sram_addr] <= sram_dq_out;
  assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 16'h0;

  // Bus activity logs
  typedef struct packed { logic [17:0] a; logic [15:0] d; } wl_t;
  wl_t         wlog[$];
  logic [17:0] rlog[$];
  always @(negedge clk) begin
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) wlog.push_back({sram_addr, sram_dq_out});
    if (!sram_ce_n && !sram_oe_n) rlog.push_back(sram_addr);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [17:0] lo;      // expected sram_addr of the low half
    logic [31:0] rdata;   // expected read_data at completion
  } vec_t;

  task automatic check_logs(input string nm, input logic wr, input logic [17:0] lo,
                            input logic [31:0] wdata);
    if (wr) begin
      chk({nm, "_wcnt"}, 64'(wlog.size()), 64'(2*W));
      chk({nm, "_rcnt"}, 64'(rlog.size()), 64'd0);
      for (int i = 0; i < 2*W && i < wlog.size(); i++)
        chk($sformatf("%s_w%0d", nm, i), 64'(wlog[i]),
            64'({lo | 18'(i >= W), (i < W) ? wdata[15:0] : wdata[31:16]}));
    end else begin
      chk({nm, "_rcnt"}, 64'(rlog.size()), 64'(2*W));
      chk({nm, "_wcnt"}, 64'(wlog.size()), 64'd0);
      for (int i = 0; i < 2*W && i < rlog.size(); i++)
        chk($sformatf("%s_r%0d", nm, i), 64'(rlog[i]), 64'(lo | 18'(i >= W)));
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int lat;
    wlog.delete(); rlog.delete();
    @(posedge clk); #1;
    bus.wr_en = v.wr; bus.rd_en = v.rd;
    bus.address = v.addr; bus.write_data = v.wdata;
    @(negedge clk);
    chk({nm, "_ready_c0"}, 64'(bus.ready), 64'd0);
    lat = -1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus.ready) begin lat = c; break; end
    end
    chk({nm, "_latency"}, 64'(lat), 64'(2*W+1));
    chk({nm, "_rdata"}, 64'(bus.read_data), 64'(v.rdata));
    check_logs(nm, v.wr, v.lo, v.wdata);
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
  endtask

  vec_t vt[9];
  vec_t rb;

  initial begin
    vt[0] = '{1'b1, 1'b0, 32'd1024,    32'hDEADBEEF, 18'h00000, 32'h00000000};
    vt[1] = '{1'b0, 1'b1, 32'd1024,    32'h0,        18'h00000, 32'hDEADBEEF};
    vt[2] = '{1'b1, 1'b1, 32'd1032,    32'h12345678, 18'h00004, 32'hDEADBEEF};
    vt[3] = '{1'b0, 1'b1, 32'd1032,    32'h0,        18'h00004, 32'h12345678};
    vt[4] = '{1'b1, 1'b0, 32'd1027,    32'hCAFEF00D, 18'h00000, 32'h12345678};
    vt[5] = '{1'b0, 1'b1, 32'd1024,    32'h0,        18'h00000, 32'hCAFEF00D};
    vt[6] = '{1'b1, 1'b0, 32'h0,       32'h0BADF00D, 18'h3FE00, 32'hCAFEF00D};
    vt[7] = '{1'b0, 1'b1, 32'h0,       32'h0,        18'h3FE00, 32'h0BADF00D};
    vt[8] = '{1'b0, 1'b1, 32'h80000,   32'h0,        18'h3FE00, 32'h0BADF00D};

    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.address = '0; bus.write_data = '0;
    rst = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("rst_ready",  64'(bus.ready),     64'd1);
    chk("rst_rdata",  64'(bus.read_data), 64'd0);
    chk("rst_addr",   64'(sram_addr),     64'd0);
    chk("rst_dqout",  64'(sram_dq_out),   64'd0);
    chk("rst_dqoe",   64'(sram_dq_oe),    64'd0);
    chk("rst_strobe", 64'({sram_we_n, sram_oe_n, sram_ce_n}), 64'd7);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    for (int i = 0; i < 9; i++) run_vec(vt[i], $sformatf("vec%0d", i));

    // Inputs change in cycle 2: the latched address/data must still be used.
    begin
      int lat;
      wlog.delete(); rlog.delete();
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.address = 32'd1040; bus.write_data = 32'h11112222;
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.address = 32'd1100; bus.write_data = 32'h99999999;
      lat = -1;
      for (int c = 2; c <= 12; c++) begin
        @(negedge clk);
        if (bus.ready) begin lat = c; break; end
      end
      chk("latch_latency", 64'(lat), 64'(2*W+1));
      check_logs("latch", 1'b1, 18'd8, 32'h11112222);
      @(posedge clk); #1;
      bus.wr_en = 1'b0;
      rb = '{1'b0, 1'b1, 32'd1040, 32'h0, 18'd8, 32'h11112222};
      run_vec(rb, "latch_rb");
    end

    // Reset asserted during HIGH of a write.
    begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.address = 32'd1024; bus.write_data = 32'hA5A55A5A;
      for (int c = 0; c <= W+1; c++) @(negedge clk);
      chk("midrst_pre_addr", 64'(sram_addr), 64'd1);
      chk("midrst_pre_we",   64'(sram_we_n), 64'd0);
      #1 rst = 1'b0;
      #1;
      chk("midrst_ready", 64'(bus.ready),   64'd1);
      chk("midrst_we",    64'(sram_we_n),   64'd1);
      chk("midrst_ce",    64'(sram_ce_n),   64'd1);
      chk("midrst_state", 64'(dut.state),   64'(IDLE));
      chk("midrst_rdata", 64'(bus.read_data), 64'd0);
      bus.wr_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
    end

    // Back-to-back reads: request held across DONE.
    begin
      logic [11:0] rv;
      rv = '0;
      @(posedge clk); #1;
      bus.rd_en = 1'b1; bus.address = 32'd1032;
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        rv[c] = bus.ready;
        if (c == 5) chk("b2b_rdata1", 64'(bus.read_data), 64'h12345678);
      end
      chk("b2b_ready_pattern", 64'(rv), 64'h820);
      chk("b2b_rdata2", 64'(bus.read_data), 64'h12345678);
      @(posedge clk); #1;
      bus.rd_en = 1'b0;
      @(negedge clk);
      chk("b2b_idle_ready", 64'(bus.ready), 64'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
